// File: rtl/uart_status_reporter.sv
`default_nettype none
// ============================================================================
// Module   : uart_status_reporter
// Brief    : Turns control pulses and mode-level changes into short ASCII
//            report messages on a valid/ready UART TX byte interface.
// Revision : 1.0 - initial release
// ============================================================================
module uart_status_reporter #(
    parameter int unsigned P_EOL_LF     = 1,
    parameter int unsigned P_REPORT_ADJ = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_mode_sel,
    input  logic       i_fnd_mode,
    input  logic       i_run,
    input  logic       i_stop,
    input  logic       i_clear,
    input  logic       i_sec_plus,
    input  logic       i_min_plus,
    input  logic       i_hour_plus,
    output logic [7:0] o_tx_data,
    output logic       o_tx_valid,
    input  logic       i_tx_ready,
    output logic       o_busy,
    output logic       o_drop
);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_SEND = 1'b1
    } state_t;

    localparam logic [2:0] c_LAST_IDX = (P_EOL_LF != 0) ? 3'd4 : 3'd3;
    localparam logic       c_ADJ_EN   = (P_REPORT_ADJ != 0);
    localparam logic [7:0] c_CR       = 8'h0D;
    localparam logic [7:0] c_LF       = 8'h0A;

    state_t      r_state;
    logic        r_mode_prev;
    logic        r_fnd_prev;
    logic [7:0]  r_pend;
    logic [2:0]  r_idx;
    logic [23:0] r_code;
    logic [7:0]  r_tx_data;
    logic        r_tx_valid;
    logic        r_busy;
    logic        r_drop;

    logic [7:0]  w_evt;
    logic [7:0]  w_sel;
    logic [7:0]  w_clr;
    logic [23:0] w_sel_code;
    logic        w_any;
    logic        w_xfer;
    logic [2:0]  w_idx_next;

    // Bit 0 is the highest priority class (MOD), bit 7 the lowest (SEC).
    assign w_evt = {i_sec_plus  & c_ADJ_EN,
                    i_min_plus  & c_ADJ_EN,
                    i_hour_plus & c_ADJ_EN,
                    i_run,
                    i_stop,
                    i_clear,
                    i_fnd_mode ^ r_fnd_prev,
                    i_mode_sel ^ r_mode_prev};

    assign w_sel      = r_pend & (~r_pend + 8'd1);
    assign w_any      = |r_pend;
    assign w_clr      = (r_state == S_IDLE) ? w_sel : 8'h00;
    assign w_xfer     = r_tx_valid & i_tx_ready;
    assign w_idx_next = r_idx + 3'd1;

    always_comb begin
        w_sel_code = 24'h000000;
        case (w_sel)
            8'h01:   w_sel_code = i_mode_sel ? "STW" : "WCH";
            8'h02:   w_sel_code = i_fnd_mode ? "FD1" : "FD0";
            8'h04:   w_sel_code = "CLR";
            8'h08:   w_sel_code = "STP";
            8'h10:   w_sel_code = "RUN";
            8'h20:   w_sel_code = "H+ ";
            8'h40:   w_sel_code = "M+ ";
            8'h80:   w_sel_code = "S+ ";
            default: w_sel_code = 24'h000000;
        endcase
    end

    function automatic logic [7:0] f_byte(input logic [23:0] code, input logic [2:0] idx);
        case (idx)
            3'd0:    f_byte = code[23:16];
            3'd1:    f_byte = code[15:8];
            3'd2:    f_byte = code[7:0];
            3'd3:    f_byte = c_CR;
            default: f_byte = c_LF;
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_mode_prev <= i_mode_sel;
            r_fnd_prev  <= i_fnd_mode;
            r_pend      <= 8'h00;
            r_idx       <= 3'd0;
            r_code      <= 24'h000000;
            r_tx_data   <= 8'h00;
            r_tx_valid  <= 1'b0;
            r_busy      <= 1'b0;
            r_drop      <= 1'b0;
        end else begin
            r_mode_prev <= i_mode_sel;
            r_fnd_prev  <= i_fnd_mode;
            // An event on a class being selected this cycle re-arms it silently.
            r_pend      <= (r_pend & ~w_clr) | w_evt;
            r_drop      <= |(w_evt & r_pend & ~w_clr);

            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_code     <= w_sel_code;
                        r_idx      <= 3'd0;
                        r_tx_data  <= w_sel_code[23:16];
                        r_tx_valid <= 1'b1;
                        r_busy     <= 1'b1;
                        r_state    <= S_SEND;
                    end
                end
                S_SEND: begin
                    if (w_xfer) begin
                        if (r_idx == c_LAST_IDX) begin
                            r_idx      <= 3'd0;
                            r_tx_valid <= 1'b0;
                            r_busy     <= 1'b0;
                            r_state    <= S_IDLE;
                        end else begin
                            r_idx     <= w_idx_next;
                            r_tx_data <= f_byte(r_code, w_idx_next);
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_tx_data  = r_tx_data;
    assign o_tx_valid = r_tx_valid;
    assign o_busy     = r_busy;
    assign o_drop     = r_drop;

endmodule
`default_nettype wire

// File: tb/tb_uart_status_reporter.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_status_reporter
// Brief    : Directed vector table plus hand-written sequences for the
//            status reporter, full (CR+LF, adjust) and lite (CR only) builds.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_status_reporter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       mode_sel = 1'b0, fnd_mode = 1'b0;
    logic       run = 1'b0, stop = 1'b0, clear = 1'b0;
    logic       sec_plus = 1'b0, min_plus = 1'b0, hour_plus = 1'b0;
    logic       tx_ready = 1'b1;
    logic [7:0] tx_data0, tx_data1;
    logic       tx_valid0, busy0, drop0;
    logic       tx_valid1, busy1, drop1;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    uart_status_reporter #(.P_EOL_LF(1), .P_REPORT_ADJ(1)) u_dut (
        .clk(clk), .rst(rst),
        .i_mode_sel(mode_sel), .i_fnd_mode(fnd_mode),
        .i_run(run), .i_stop(stop), .i_clear(clear),
        .i_sec_plus(sec_plus), .i_min_plus(min_plus), .i_hour_plus(hour_plus),
        .o_tx_data(tx_data0), .o_tx_valid(tx_valid0), .i_tx_ready(tx_ready),
        .o_busy(busy0), .o_drop(drop0)
    );

    uart_status_reporter #(.P_EOL_LF(0), .P_REPORT_ADJ(0)) u_dut_lite (
        .clk(clk), .rst(rst),
        .i_mode_sel(mode_sel), .i_fnd_mode(fnd_mode),
        .i_run(run), .i_stop(stop), .i_clear(clear),
        .i_sec_plus(sec_plus), .i_min_plus(min_plus), .i_hour_plus(hour_plus),
        .o_tx_data(tx_data1), .o_tx_valid(tx_valid1), .i_tx_ready(tx_ready),
        .o_busy(busy1), .o_drop(drop1)
    );

    // pulses = {hour, min, sec, clear, stop, run}
    typedef struct {
        logic       rst;
        logic       mode;
        logic       fnd;
        logic [5:0] pulses;
        logic       ready;
        logic       exp_valid;
        logic [7:0] exp_data;
        logic       chk_data;
        logic       exp_busy;
        logic       exp_drop;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, input logic m, input logic f, input logic [5:0] p,
                       input logic rdy, input logic ev, input logic [7:0] ed,
                       input logic cd, input logic eb, input logic edr);
        vec_t v;
        v.rst = r; v.mode = m; v.fnd = f; v.pulses = p; v.ready = rdy;
        v.exp_valid = ev; v.exp_data = ed; v.chk_data = cd;
        v.exp_busy = eb; v.exp_drop = edr;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%02h, expected 0x%02h", name, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic m, input logic f,
                         input logic [5:0] p, input logic rdy);
        rst = r; mode_sel = m; fnd_mode = f; tx_ready = rdy;
        {hour_plus, min_plus, sec_plus, clear, stop, run} = p;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Waits for a message start, then checks n bytes with ready held high.
    task automatic recv(input bit lite, input logic [39:0] exp, input int n,
                        input int max_wait, input string name);
        int w = 0;
        while (!(lite ? tx_valid1 : tx_valid0) && w < max_wait) begin
            step();
            w++;
        end
        check({name, " start"}, {7'd0, (lite ? tx_valid1 : tx_valid0)}, 8'd1);
        if (lite ? tx_valid1 : tx_valid0) begin
            for (int i = 0; i < n; i++) begin
                check($sformatf("%s byte%0d", name, i), lite ? tx_data1 : tx_data0,
                      exp[39 - 8*i -: 8]);
                step();
            end
        end
        check({name, " end valid"}, {7'd0, (lite ? tx_valid1 : tx_valid0)}, 8'd0);
    endtask

    initial begin
        int w;
        int seen;

        // RUN message, two STP pulses during it, then one STP message.
        add(1, 0, 0, 6'b000000, 1, 0, 8'h00, 1, 0, 0);
        add(0, 0, 0, 6'b000001, 1, 0, 8'h00, 1, 0, 0);
        add(0, 0, 0, 6'b000000, 1, 1, 8'h52, 1, 1, 0);
        add(0, 0, 0, 6'b000010, 1, 1, 8'h55, 1, 1, 0);
        add(0, 0, 0, 6'b000000, 1, 1, 8'h4E, 1, 1, 0);
        add(0, 0, 0, 6'b000010, 1, 1, 8'h0D, 1, 1, 1);
        add(0, 0, 0, 6'b000000, 1, 1, 8'h0A, 1, 1, 0);
        add(0, 0, 0, 6'b000000, 1, 0, 8'h00, 0, 0, 0);
        add(0, 0, 0, 6'b000000, 1, 1, 8'h53, 1, 1, 0);
        add(0, 0, 0, 6'b000000, 1, 1, 8'h54, 1, 1, 0);
        add(0, 0, 0, 6'b000000, 1, 1, 8'h50, 1, 1, 0);
        add(0, 0, 0, 6'b000000, 1, 1, 8'h0D, 1, 1, 0);
        add(0, 0, 0, 6'b000000, 1, 1, 8'h0A, 1, 1, 0);
        add(0, 0, 0, 6'b000000, 1, 0, 8'h00, 0, 0, 0);
        add(0, 0, 0, 6'b000000, 1, 0, 8'h00, 0, 0, 0);
        // Mode 0->1 with ready held low: 'S' must hold.
        add(0, 1, 0, 6'b000000, 0, 0, 8'h00, 0, 0, 0);
        add(0, 1, 0, 6'b000000, 0, 1, 8'h53, 1, 1, 0);
        for (int i = 0; i < 10; i++)
            add(0, 1, 0, 6'b000000, 0, 1, 8'h53, 1, 1, 0);
        add(0, 1, 0, 6'b000000, 1, 1, 8'h54, 1, 1, 0);
        add(0, 1, 0, 6'b000000, 1, 1, 8'h57, 1, 1, 0);
        add(0, 1, 0, 6'b000000, 1, 1, 8'h0D, 1, 1, 0);
        add(0, 1, 0, 6'b000000, 1, 1, 8'h0A, 1, 1, 0);
        add(0, 1, 0, 6'b000000, 1, 0, 8'h00, 0, 0, 0);

        foreach (vecs[k]) begin
            drive(vecs[k].rst, vecs[k].mode, vecs[k].fnd, vecs[k].pulses, vecs[k].ready);
            step();
            check($sformatf("v%0d valid", k), {7'd0, tx_valid0}, {7'd0, vecs[k].exp_valid});
            if (vecs[k].chk_data)
                check($sformatf("v%0d data", k), tx_data0, vecs[k].exp_data);
            check($sformatf("v%0d busy", k), {7'd0, busy0}, {7'd0, vecs[k].exp_busy});
            check($sformatf("v%0d drop", k), {7'd0, drop0}, {7'd0, vecs[k].exp_drop});
        end

        // CLR and S+ in the same cycle: two messages, one idle cycle apart.
        drive(0, 1, 0, 6'b001100, 1);
        step();
        drive(0, 1, 0, 6'b000000, 1);
        recv(0, 40'h434C520D0A, 5, 3, "clr");
        recv(0, 40'h532B200D0A, 5, 1, "sec");

        // Reset after two bytes of FD1.
        drive(0, 1, 1, 6'b000000, 1);
        step();
        w = 0;
        while (!tx_valid0 && w < 4) begin
            step();
            w++;
        end
        check("fd1 byte0", tx_data0, 8'h46);
        step();
        check("fd1 byte1", tx_data0, 8'h44);
        step();
        drive(1, 1, 1, 6'b000000, 1);
        step();
        check("rst abort valid", {7'd0, tx_valid0}, 8'd0);
        check("rst abort busy", {7'd0, busy0}, 8'd0);
        drive(0, 1, 1, 6'b000000, 1);
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (tx_valid0) seen++;
        end
        check("rst no resume", seen[7:0], 8'd0);

        // Lite build: H+ is ignored, STP is sent with CR only.
        drive(1, 1, 1, 6'b000000, 1);
        step();
        step();
        drive(0, 1, 1, 6'b100000, 1);
        step();
        drive(0, 1, 1, 6'b000010, 1);
        step();
        drive(0, 1, 1, 6'b000000, 1);
        recv(1, 40'h5354500D00, 4, 4, "lite stp");
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (tx_valid1) seen++;
        end
        check("lite no hplus", seen[7:0], 8'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
